// File: rtl/nonce_scheduler.sv
// Two-lane nonce scheduler: issues consecutive nonces to two hash lanes offset by
// half a hash, checks each lane result against the target and reports the first winner.
module nonce_scheduler #(
    parameter int ROUNDS = 64,
    parameter int CW     = 6,
    parameter int HW     = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [95:0]   header_in,
    input  logic [31:0]   nonce_first,
    input  logic [31:0]   nonce_last,
    input  logic [HW-1:0] target,
    input  logic [HW-1:0] hash_0,
    input  logic [HW-1:0] hash_1,
    output logic [95:0]   entrada,
    output logic [31:0]   nonce,
    output logic [CW-1:0] counter,
    output logic [CW-1:0] counter_2d,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [31:0]   golden_nonce,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] HALF = CW'(ROUNDS / 2);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   nonce_q;
    logic [31:0]   last_q;
    logic [HW-1:0] target_q;
    logic [95:0]   entrada_q;
    logic [31:0]   golden_q;
    logic          found_q;
    logic          done_q;
    logic          busy_q;
    logic          arm0_q;
    logic          arm1_q;
    logic          arm0_d;
    logic          arm1_d;
    logic [31:0]   inflight0_q;
    logic [31:0]   inflight1_q;

    logic [CW-1:0] cnt_2d;
    logic          issue0;
    logic          issue1;
    logic          chk0;
    logic          chk1;
    logic          hit0;
    logic          hit1;
    logic          last_issue;
    logic          drain_empty;

    // Lane 1 trails lane 0 by half a hash; 2^CW == ROUNDS makes the add wrap for free.
    assign cnt_2d      = cnt_q + HALF;
    assign cnt_d       = cnt_q + CW'(1);
    assign issue0      = (state_q == RUN) && (cnt_q == '0);
    assign issue1      = (state_q == RUN) && (cnt_2d == '0);
    assign chk0        = (state_q != IDLE) && (cnt_q == LAST) && arm0_q;
    assign chk1        = (state_q != IDLE) && (cnt_2d == LAST) && arm1_q;
    assign hit0        = chk0 && (hash_0 < target_q);
    assign hit1        = chk1 && (hash_1 < target_q);
    assign last_issue  = (issue0 || issue1) && (nonce_q == last_q);
    assign arm0_d      = issue0 || (arm0_q && !chk0);
    assign arm1_d      = issue1 || (arm1_q && !chk1);
    assign drain_empty = (state_q == DRAIN) && !arm0_d && !arm1_d;

    // start is a level request with no ready: it is taken on any edge that finds the block
    // in IDLE and ignored otherwise; abort is only honoured in RUN or DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nonce_q     <= '0;
            last_q      <= '0;
            target_q    <= '0;
            entrada_q   <= '0;
            golden_q    <= '0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            arm0_q      <= 1'b0;
            arm1_q      <= 1'b0;
            inflight0_q <= '0;
            inflight1_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        entrada_q <= header_in;
                        nonce_q   <= nonce_first;
                        last_q    <= nonce_last;
                        target_q  <= target;
                        golden_q  <= '0;
                        found_q   <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                default: begin
                    if (abort) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        arm0_q  <= 1'b0;
                        arm1_q  <= 1'b0;
                    end else if (hit0 || hit1) begin
                        golden_q <= hit0 ? inflight0_q : inflight1_q;
                        found_q  <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        arm0_q   <= 1'b0;
                        arm1_q   <= 1'b0;
                    end else if (drain_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        arm0_q  <= 1'b0;
                        arm1_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        arm0_q <= arm0_d;
                        arm1_q <= arm1_d;
                        if (issue0) begin
                            inflight0_q <= nonce_q;
                        end
                        if (issue1) begin
                            inflight1_q <= nonce_q;
                        end
                        // The final nonce never increments, so a full 32-bit range cannot wrap.
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end else if (issue0 || issue1) begin
                            nonce_q <= nonce_q + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign entrada      = entrada_q;
    assign nonce        = nonce_q;
    assign counter      = cnt_q;
    assign counter_2d   = cnt_2d;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign golden_nonce = golden_q;
    assign state_o      = state_q;

endmodule
